alu_ctrl: RTL and testbench
===========================

Name: alu_ctrl

Overview:
Initiator for the registered 2-bit-opcode ALU port (Opc/DinA/DinB in, Dout/OverFlow out, fixed latency). Accepts operation requests over a valid/ready handshake, drives the ALU operands, and waits the configured latency. It captures the result and overflow flag and returns them over a second valid/ready handshake. It sits between a command source (sequencer or bus bridge) and one ALU instance. It also supports operand chaining from the previous result.

Parameters:
WIDTH, 32, operand/result width
ALU_LATENCY, 1, cycles from ALU input sample to valid Dout/OverFlow (>=1)

Ports:
Clk_i  in  1  clock, rising edge
Reset_i  in  1  asynchronous active-high reset
ReqValid_i  in  1  request valid
ReqReady_o  out  1  request accepted when ReqValid_i && ReqReady_o
ReqOpc_i  in  2  0=ADD 1=SUB 2=AND 3=OR
ReqDinA_i  in  WIDTH  operand A
ReqDinB_i  in  WIDTH  operand B
ReqChain_i  in  1  1: use last captured result as operand A; ReqDinA_i is ignored
AluOpc_o  out  2  to ALU Opc
AluDinA_o  out  WIDTH  to ALU DinA
AluDinB_o  out  WIDTH  to ALU DinB
AluDout_i  in  WIDTH  from ALU Dout
AluOverFlow_i  in  1  from ALU OverFlow
RspValid_o  out  1  response valid
RspReady_i  in  1  response consumed when RspValid_o && RspReady_i
RspDout_o  out  WIDTH  captured result
RspOverFlow_o  out  1  captured overflow
Busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, Reset_i=1): state IDLE; ReqReady_o=1, RspValid_o=0, RspDout_o=0, RspOverFlow_o=0, AluOpc_o=0, AluDinA_o=0, AluDinB_o=0, Busy_o=0, last-result register=0, latency counter=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: ReqReady_o=1. On handshake, register the operands onto the Alu*_o outputs. The registers are not combinational from the Req* ports. AluDinA_o = last-result if ReqChain_i, else ReqDinA_i. Go to ISSUE.
- ISSUE: ALU samples operands at this cycle's edge. Load counter with ALU_LATENCY-1. Go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0, capture AluDout_i/AluOverFlow_i into Rsp*_o and the last-result register, then go to RESP. With ALU_LATENCY=1 the capture occurs on the first WAIT cycle.
- RESP: RspValid_o=1, Rsp*_o held stable until the handshake. On handshake go to IDLE with RspValid_o=0 on the next cycle.
- ReqReady_o=1 only in IDLE. Request-to-response minimum latency = ALU_LATENCY+2 cycles. Throughput is at most one operation per ALU_LATENCY+3 cycles.
- Alu*_o hold their last values outside IDLE→ISSUE updates. This keeps the ALU output stable.
- ReqChain_i in the first request after reset uses 0 as operand A.
- Req* is ignored when ReqReady_o=0. RspReady_i is ignored when RspValid_o=0.
- Reset asserted mid-operation aborts the in-flight operation. No response is produced and the last result is cleared.
- ALU overflow is passed through unchanged: carry-out for ADD, borrow for SUB, 0 for AND/OR. The controller does not recompute it.

Optional Feature:
ALU_CTRL_OVF_CNT_EN: when defined, adds port OvfCnt_o (out, 16) counting captured responses with overflow=1. It saturates at 16'hFFFF, resets to 0, and increments in the capture cycle. When undefined, the port and counter are absent and the rest of the behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - the opcode enum (OPC_ADD=0, OPC_SUB=1, OPC_AND=2, OPC_OR=3), shared with the ALU and benches;
  - the FSM state typedef;
  - the default WIDTH constant.
- No sub-module is needed. The latency counter is small enough to stay inline.

Test Plan:
- Reset, then ADD 32'h0000_0005 + 32'h0000_0003 with RspReady_i=1 → RspValid_o after 3 cycles (ALU_LATENCY=1), RspDout_o=8, RspOverFlow_o=0.
- ADD 32'hFFFF_FFFF + 1 → RspDout_o=0, RspOverFlow_o=1. SUB 0 − 1 → 32'hFFFF_FFFF, RspOverFlow_o=1.
- AND 32'hF0F0_F0F0, 32'hFF00_FF00 → 32'hF000_F000. Then OR with ReqChain_i=1, B=32'h0000_000F → 32'hF000_F00F.
- RspReady_i=0 for 5 cycles → RspValid_o and RspDout_o stable, ReqReady_o=0, and a new ReqValid_i is not accepted until 1 cycle after the response handshake.
- Reset asserted during WAIT → all outputs at reset values immediately, no RspValid_o afterwards. A subsequent chained ADD with B=7 → result 7.
- With ALU_CTRL_OVF_CNT_EN and ALU_LATENCY=3: three overflowing ADDs → OvfCnt_o=3, each response 5 cycles after its request handshake.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, controller FSM states and the default data width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    OPC_ADD = 2'd0,
    OPC_SUB = 2'd1,
    OPC_AND = 2'd2,
    OPC_OR  = 2'd3
  } alu_opc_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } alu_ctrl_state_e;

endpackage

// File: rtl/alu_ctrl.sv
// Request/response front end for a fixed-latency registered ALU, with optional result chaining.
// Optional overflow counter output OvfCnt_o is built when ALU_CTRL_OVF_CNT_EN is defined.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH       = ALU_WIDTH,
  parameter int ALU_LATENCY = 1
) (
  input  logic             Clk_i,
  input  logic             Reset_i,
  input  logic             ReqValid_i,
  output logic             ReqReady_o,
  input  logic [1:0]       ReqOpc_i,
  input  logic [WIDTH-1:0] ReqDinA_i,
  input  logic [WIDTH-1:0] ReqDinB_i,
  input  logic             ReqChain_i,
  output logic [1:0]       AluOpc_o,
  output logic [WIDTH-1:0] AluDinA_o,
  output logic [WIDTH-1:0] AluDinB_o,
  input  logic [WIDTH-1:0] AluDout_i,
  input  logic             AluOverFlow_i,
  output logic             RspValid_o,
  input  logic             RspReady_i,
  output logic [WIDTH-1:0] RspDout_o,
  output logic             RspOverFlow_o,
  output logic             Busy_o
`ifdef ALU_CTRL_OVF_CNT_EN
  ,
  output logic [15:0]      OvfCnt_o
`endif
);

  localparam int CW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

  alu_ctrl_state_e  state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       opc_q, opc_d;
  logic [WIDTH-1:0] din_a_q, din_a_d;
  logic [WIDTH-1:0] din_b_q, din_b_d;
  logic [WIDTH-1:0] rsp_dout_q, rsp_dout_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             capture;

  assign capture = (state_q == ST_WAIT) && (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opc_d      = opc_q;
    din_a_d    = din_a_q;
    din_b_d    = din_b_q;
    rsp_dout_d = rsp_dout_q;
    rsp_ovf_d  = rsp_ovf_q;
    last_d     = last_q;
    case (state_q)
      ST_IDLE: begin
        if (ReqValid_i) begin
          opc_d   = ReqOpc_i;
          din_a_d = ReqChain_i ? last_q : ReqDinA_i;
          din_b_d = ReqDinB_i;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CW'(ALU_LATENCY - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (capture) begin
          rsp_dout_d = AluDout_i;
          rsp_ovf_d  = AluOverFlow_i;
          last_d     = AluDout_i;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (RspReady_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      opc_q      <= '0;
      din_a_q    <= '0;
      din_b_q    <= '0;
      rsp_dout_q <= '0;
      rsp_ovf_q  <= 1'b0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opc_q      <= opc_d;
      din_a_q    <= din_a_d;
      din_b_q    <= din_b_d;
      rsp_dout_q <= rsp_dout_d;
      rsp_ovf_q  <= rsp_ovf_d;
      last_q     <= last_d;
    end
  end

  assign ReqReady_o    = (state_q == ST_IDLE);
  assign RspValid_o    = (state_q == ST_RESP);
  assign Busy_o        = (state_q != ST_IDLE);
  assign AluOpc_o      = opc_q;
  assign AluDinA_o     = din_a_q;
  assign AluDinB_o     = din_b_q;
  assign RspDout_o     = rsp_dout_q;
  assign RspOverFlow_o = rsp_ovf_q;

`ifdef ALU_CTRL_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  // Saturating count of overflowing results, bumped in the capture cycle.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (capture && AluOverFlow_i && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) ovf_cnt_q <= '0;
    else         ovf_cnt_q <= ovf_cnt_d;
  end

  assign OvfCnt_o = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural registered ALU; uses latency 3 when ALU_CTRL_OVF_CNT_EN is defined.
module tb_alu_ctrl;
  import alu_pkg::*;

`ifdef ALU_CTRL_OVF_CNT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_chain;
  logic [1:0]  req_opc;
  logic [31:0] req_a, req_b;
  logic [1:0]  alu_opc;
  logic [31:0] alu_a, alu_b, alu_dout;
  logic        alu_ovf;
  logic        rsp_valid, rsp_ready, rsp_ovf, busy;
  logic [31:0] rsp_dout;
`ifdef ALU_CTRL_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  always #5 clk = ~clk;

  alu_ctrl #(.WIDTH(32), .ALU_LATENCY(LAT)) dut (
    .Clk_i(clk), .Reset_i(rst),
    .ReqValid_i(req_valid), .ReqReady_o(req_ready), .ReqOpc_i(req_opc),
    .ReqDinA_i(req_a), .ReqDinB_i(req_b), .ReqChain_i(req_chain),
    .AluOpc_o(alu_opc), .AluDinA_o(alu_a), .AluDinB_o(alu_b),
    .AluDout_i(alu_dout), .AluOverFlow_i(alu_ovf),
    .RspValid_o(rsp_valid), .RspReady_i(rsp_ready),
    .RspDout_o(rsp_dout), .RspOverFlow_o(rsp_ovf), .Busy_o(busy)
`ifdef ALU_CTRL_OVF_CNT_EN
    , .OvfCnt_o(ovf_cnt)
`endif
  );

  // Behavioural ALU: samples every edge, result appears LAT edges later.
  function automatic logic [32:0] alu_f(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      2'd0:    alu_f = {1'b0, a} + {1'b0, b};
      2'd1:    alu_f = {(a < b), a - b};
      2'd2:    alu_f = {1'b0, a & b};
      default: alu_f = {1'b0, a | b};
    endcase
  endfunction

  logic [32:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= alu_f(alu_opc, alu_a, alu_b);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign alu_dout = pipe[LAT-1][31:0];
  assign alu_ovf  = pipe[LAT-1][32];

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_exp = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full request/response; caller leaves rsp_ready=1.
  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic ch, input logic [31:0] exp_d, input logic exp_v);
    int lat;
    int w;
    logic [31:0] exp_a;
    exp_a = ch ? last_exp : a;
    w = 0;
    while (!req_ready && w < 20) begin @(posedge clk); #1; w++; end
    check({name, "_ready"}, 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_opc = o; req_a = a; req_b = b; req_chain = ch;
    @(posedge clk); #1;
    req_valid = 1'b0; req_a = 32'hDEAD_BEEF; req_b = 32'hBAD0_BAD0; req_chain = 1'b0;
    check({name, "_alu_in"}, {30'd0, alu_opc, alu_a}, {30'd0, o, exp_a});
    check({name, "_alu_b"}, 64'(alu_b), 64'(b));
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check({name, "_latency"}, 64'(lat), 64'(LAT + 2));
    check({name, "_dout"}, 64'(rsp_dout), 64'(exp_d));
    check({name, "_ovf"}, 64'(rsp_ovf), 64'(exp_v));
    last_exp = exp_d;
    @(posedge clk); #1;
    check({name, "_rsp_done"}, 64'(rsp_valid), 64'(0));
    $display("op %s opc=%0d a=%h b=%h chain=%0b -> dout=%h ovf=%0b lat=%0d", name, o, a, b, ch, rsp_dout, rsp_ovf, lat);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  opc;
    logic [31:0] a, b;
    logic        chain;
    logic [31:0] dout;
    logic        ovf;
  } vec_t;
  vec_t vecs[7];

  initial begin
    logic stable;
    logic saw_rsp;
    vecs[0] = '{"add_5_3",    2'd0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0};
    vecs[1] = '{"add_wrap",   2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
    vecs[2] = '{"sub_borrow", 2'd1, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1};
    vecs[3] = '{"and",        2'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'hF000_F000, 1'b0};
    vecs[4] = '{"or_chain",   2'd3, 32'h1234_5678, 32'h0000_000F, 1'b1, 32'hF000_F00F, 1'b0};
    vecs[5] = '{"sub_chain",  2'd1, 32'h0000_0000, 32'h0000_0010, 1'b1, 32'hF000_EFFF, 1'b0};
    vecs[6] = '{"add_chain",  2'd0, 32'h0000_0000, 32'h0FFF_1001, 1'b1, 32'h0000_0000, 1'b1};

    rst = 1'b1; req_valid = 1'b0; req_opc = 2'd0; req_a = '0; req_b = '0; req_chain = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {req_ready, rsp_valid, busy, rsp_ovf, alu_opc}, {1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
    check("rst_data", {rsp_dout, alu_a | alu_b}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      do_op(vecs[i].name, vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].chain, vecs[i].dout, vecs[i].ovf);
`ifdef ALU_CTRL_OVF_CNT_EN
    check("ovf_cnt_3", 64'(ovf_cnt), 64'(3));
`endif

    // Response back-pressure: held response, second request waits.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_opc = 2'd0; req_a = 32'd100; req_b = 32'd23; req_chain = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    begin
      int w = 0;
      while (!rsp_valid && w < 40) begin @(posedge clk); #1; w++; end
    end
    check("stall_rsp_valid", 64'(rsp_valid), 64'(1));
    req_valid = 1'b1; req_opc = 2'd3; req_a = 32'd1; req_b = 32'd2;
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (!(rsp_valid && rsp_dout == 32'd123 && !req_ready && busy && alu_b == 32'd23)) stable = 1'b0;
    end
    check("stall_hold", 64'(stable), 64'(1));
    $display("stall: held dout=%h for 5 cycles", rsp_dout);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release", {rsp_valid, req_ready, busy}, {1'b0, 1'b1, 1'b0});
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("stall_next_accept", {busy, alu_opc, alu_b}, {1'b1, 2'd3, 32'd2});
    begin
      int w = 0;
      while (!rsp_valid && w < 40) begin @(posedge clk); #1; w++; end
    end
    check("stall_next_dout", {rsp_valid, rsp_dout}, {1'b1, 32'd3});
    @(posedge clk); #1;
    $display("stall: follow-up OR result=3 consumed");

    // Reset during WAIT aborts the operation and clears the last result.
    req_valid = 1'b1; req_opc = 2'd0; req_a = 32'd1; req_b = 32'd1; req_chain = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_ctrl", {req_ready, rsp_valid, busy, rsp_ovf, alu_opc}, {1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
    check("mid_rst_data", {rsp_dout, alu_a | alu_b}, 64'd0);
`ifdef ALU_CTRL_OVF_CNT_EN
    check("mid_rst_ovf_cnt", 64'(ovf_cnt), 64'(0));
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    saw_rsp = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check("mid_no_rsp", 64'(saw_rsp), 64'(0));
    $display("reset mid-op: no response seen");
    last_exp = 32'h0;
    do_op("chain_after_rst", 2'd0, 32'h5555_5555, 32'd7, 1'b1, 32'd7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
